// File: rtl/eth_phy_rx_block_lock_if.sv
// rtl/eth_phy_rx_block_lock_if.sv - SERDES/gearbox sync-header link bundle
//
// Purpose: carries the 66b sync header stream from the gearbox into the
// block-lock logic, and carries the bitslip request back to the gearbox.
// Signals:
//   serdes_rx_hdr        2  sync header of the current 66b block
//   serdes_rx_hdr_valid  1  header qualifier (0 = gearbox stall)
//   serdes_rx_bitslip    1  slip request back to the SERDES/gearbox
// Modports:
//   master  gearbox side (drives headers, receives bitslip)
//   slave   block-lock side (receives headers, drives bitslip)

interface eth_phy_rx_block_lock_if;
  logic [1:0] serdes_rx_hdr;
  logic       serdes_rx_hdr_valid;
  logic       serdes_rx_bitslip;

  modport master (
    output serdes_rx_hdr,
    output serdes_rx_hdr_valid,
    input  serdes_rx_bitslip
  );

  modport slave (
    input  serdes_rx_hdr,
    input  serdes_rx_hdr_valid,
    output serdes_rx_bitslip
  );
endinterface

// File: rtl/eth_phy_rx_block_lock.sv
// rtl/eth_phy_rx_block_lock.sv - 64b/66b receive block lock state machine
//
// Purpose: hunts for 66b block alignment by checking sync headers, slipping
// the gearbox on bad headers until LOCK_CNT consecutive good headers are
// seen, then monitors header quality per WINDOW and drops lock when
// INVALID_MAX bad headers occur within one window.
// Ports:
//   rx_clk              in   receive clock
//   rx_rst_n            in   asynchronous active-low reset
//   serdes              if   slave side of the header / bitslip bundle
//   cfg_force_unlock    in   level, holds the block unlocked
//   cfg_clear_loss_cnt  in   pulse, clears rx_lock_loss_count
//   rx_block_lock       out  block lock status
//   rx_sh_invalid       out  one-cycle pulse per accepted invalid header
//   rx_lock_loss_count  out  saturating count of lock losses

module eth_phy_rx_block_lock #(
  parameter int LOCK_CNT            = 64,
  parameter int WINDOW              = 64,
  parameter int INVALID_MAX         = 16,
  parameter int BITSLIP_HIGH_CYCLES = 1,
  parameter int BITSLIP_LOW_CYCLES  = 8,
  parameter int LOSS_CNT_WIDTH      = 8
) (
  input  logic                      rx_clk,
  input  logic                      rx_rst_n,
  eth_phy_rx_block_lock_if.slave    serdes,
  input  logic                      cfg_force_unlock,
  input  logic                      cfg_clear_loss_cnt,
  output logic                      rx_block_lock,
  output logic                      rx_sh_invalid,
  output logic [LOSS_CNT_WIDTH-1:0] rx_lock_loss_count
);

  localparam int CNT_MAX = (LOCK_CNT > WINDOW) ? LOCK_CNT : WINDOW;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int INV_W   = $clog2(INVALID_MAX + 1);
  localparam int TMR_MAX = (BITSLIP_HIGH_CYCLES > BITSLIP_LOW_CYCLES) ?
                           BITSLIP_HIGH_CYCLES : BITSLIP_LOW_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CNT - 1);
  localparam logic [CNT_W-1:0] WIN_LAST  = CNT_W'(WINDOW - 1);
  localparam logic [INV_W-1:0] INV_LAST  = INV_W'(INVALID_MAX - 1);
  localparam logic [TMR_W-1:0] HIGH_LAST = TMR_W'(BITSLIP_HIGH_CYCLES - 1);
  localparam logic [TMR_W-1:0] LOW_LAST  =
    TMR_W'((BITSLIP_LOW_CYCLES > 0) ? BITSLIP_LOW_CYCLES - 1 : 0);

  typedef enum logic [1:0] {ST_UNLOCKED, ST_LOCKED, ST_SLIP, ST_BLANK} state_t;

  state_t            state;
  logic [CNT_W-1:0]  sh_cnt;
  logic [INV_W-1:0]  sh_invalid_cnt;
  logic [TMR_W-1:0]  timer;
  logic              bitslip_q;
  logic              accept;
  logic              hdr_ok;
  logic              loss_inc;

  // 01 and 10 are the only legal sync headers.
  assign hdr_ok = serdes.serdes_rx_hdr[1] ^ serdes.serdes_rx_hdr[0];

  assign accept = serdes.serdes_rx_hdr_valid && !cfg_force_unlock &&
                  (state == ST_UNLOCKED || state == ST_LOCKED);

  // A lock loss is either the INVALID_MAX-th bad header in a window or a
  // forced unlock while locked; both leave LOCKED on this edge.
  assign loss_inc = (state == ST_LOCKED) &&
                    (cfg_force_unlock ||
                     (accept && !hdr_ok && sh_invalid_cnt == INV_LAST));

  assign serdes.serdes_rx_bitslip = bitslip_q;

  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      state          <= ST_UNLOCKED;
      sh_cnt         <= '0;
      sh_invalid_cnt <= '0;
      timer          <= '0;
      bitslip_q      <= 1'b0;
      rx_block_lock  <= 1'b0;
      rx_sh_invalid  <= 1'b0;
    end else begin
      rx_sh_invalid <= accept && !hdr_ok;
      if (cfg_force_unlock) begin
        state          <= ST_UNLOCKED;
        sh_cnt         <= '0;
        sh_invalid_cnt <= '0;
        timer          <= '0;
        bitslip_q      <= 1'b0;
        rx_block_lock  <= 1'b0;
      end else begin
        case (state)
          ST_UNLOCKED: begin
            if (accept) begin
              if (!hdr_ok) begin
                state     <= ST_SLIP;
                sh_cnt    <= '0;
                timer     <= '0;
                bitslip_q <= 1'b1;
              end else if (sh_cnt == LOCK_LAST) begin
                state          <= ST_LOCKED;
                sh_cnt         <= '0;
                sh_invalid_cnt <= '0;
                rx_block_lock  <= 1'b1;
              end else begin
                sh_cnt <= sh_cnt + CNT_W'(1);
              end
            end
          end
          ST_LOCKED: begin
            if (accept) begin
              if (!hdr_ok && sh_invalid_cnt == INV_LAST) begin
                state          <= ST_SLIP;
                sh_cnt         <= '0;
                sh_invalid_cnt <= '0;
                timer          <= '0;
                bitslip_q      <= 1'b1;
                rx_block_lock  <= 1'b0;
              end else if (sh_cnt == WIN_LAST) begin
                sh_cnt         <= '0;
                sh_invalid_cnt <= '0;
              end else begin
                sh_cnt         <= sh_cnt + CNT_W'(1);
                sh_invalid_cnt <= sh_invalid_cnt + INV_W'(!hdr_ok);
              end
            end
          end
          ST_SLIP: begin
            if (timer == HIGH_LAST) begin
              timer     <= '0;
              bitslip_q <= 1'b0;
              state     <= (BITSLIP_LOW_CYCLES == 0) ? ST_UNLOCKED : ST_BLANK;
            end else begin
              timer <= timer + TMR_W'(1);
            end
          end
          ST_BLANK: begin
            if (timer == LOW_LAST) begin
              timer  <= '0;
              sh_cnt <= '0;
              state  <= ST_UNLOCKED;
            end else begin
              timer <= timer + TMR_W'(1);
            end
          end
          default: begin
            state     <= ST_UNLOCKED;
            bitslip_q <= 1'b0;
          end
        endcase
      end
    end
  end

  // Clear wins over the old value but not over a same-cycle loss event.
  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      rx_lock_loss_count <= '0;
    end else if (cfg_clear_loss_cnt) begin
      rx_lock_loss_count <= LOSS_CNT_WIDTH'(loss_inc);
    end else if (loss_inc && rx_lock_loss_count != '1) begin
      rx_lock_loss_count <= rx_lock_loss_count + LOSS_CNT_WIDTH'(1);
    end
  end

endmodule
